instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the single-issue MIPS datapath; the requesting side of the instruction memory's read interface. It holds the program counter, drives a word address to the combinational instruction memory each cycle, and registers the returned word into the IF/ID pipeline register. Branch/jump redirects, flushes and decode stalls are resolved here, so later stages only ever see one well-defined instruction per cycle.

## Interface
- ADDR_W, 8, width of the PC and memory word address (memory depth 2^ADDR_W words)
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_addr  output  ADDR_W  word address to instruction memory (equals PC)
- imem_data  input  32  instruction word returned combinationally for imem_addr
- stall  input  1  hold PC and IF/ID (load-use hazard from decode)
- redirect  input  1  taken branch or jump resolved downstream
- redirect_target  input  ADDR_W  word address to fetch next when redirect=1
- if_id_instr  output  32  registered instruction
- if_id_pc_plus1  output  ADDR_W  registered PC+1 of that instruction
- if_id_valid  output  1  if_id_instr is a real fetched instruction (0 = bubble)

## Operation
- PC is a word index; sequential increment is +1 modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8). imem_addr = PC, purely combinational.
- Per-edge priority, highest first:
  - reset: PC <= RESET_PC; if_id_instr <= 0; if_id_pc_plus1 <= 0; if_id_valid <= 0.
  - redirect: PC <= redirect_target; IF/ID flushed (instr <= 0, pc_plus1 <= 0, valid <= 0). Overrides stall in the same cycle.
  - stall: PC, if_id_instr, if_id_pc_plus1, if_id_valid all hold.
  - normal: if_id_instr <= imem_data; if_id_pc_plus1 <= PC+1; if_id_valid <= 1; PC <= PC+1.
- No state machine beyond the PC/IF/ID registers; flush bubble is all-zero (MIPS NOP) with valid=0.
- redirect_target equal to current PC is legal: refetch after one bubble.
- Inputs stall/redirect are sampled only at the clock edge; glitches between edges have no effect except via imem_addr.

## Timing
- Fetch latency 1 cycle: PC=p in cycle N -> if_id_instr=mem[p], if_id_pc_plus1=p+1, if_id_valid=1 in cycle N+1.
- Reset asserted at edge E: all outputs at reset values from E; imem_addr=RESET_PC from E. First valid instruction at the first unstalled edge after reset deasserts.
- Reset mid-stall or mid-redirect: reset wins, pending redirect discarded.
- Redirect at edge E: bubble in cycle E+1, instruction at target valid in cycle E+2 (redirect penalty exactly 1 bubble at this stage).
- Stall held k cycles: IF/ID and PC frozen k cycles; sequence resumes with no instruction lost or duplicated.
- Throughput: one instruction per cycle with stall=redirect=0.

## Configuration
- IFETCH_PERF_EN defined: adds outputs fetch_count (32-bit, counts edges that load valid=1) and bubble_count (32-bit, counts edges that load valid=0 outside reset, i.e. redirects); both reset to 0, hold during stall, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Bench memory image word0=0x0000007E, word2=0x00000005, word5=0x000003FF, rest 0. Reset 2 cycles then release -> if_id_instr sequence 0x7E, 0x0, 0x5, 0x0, 0x0, 0x3FF with pc_plus1 1..6, valid=1 every cycle.
- stall=1 for 3 cycles while if_id_instr=0x5 (pc_plus1=3) -> outputs and imem_addr=3 frozen 3 cycles, then 0x0 (pc_plus1=4) follows.
- redirect=1, target=5 while PC=1 -> next cycle valid=0, instr=0; following cycle instr=0x3FF, pc_plus1=6, valid=1.
- redirect and stall together, target=0 -> redirect wins: bubble, then 0x7E with pc_plus1=1.
- Force PC to 0xFF via redirect -> after mem[0xFF] fetch, pc_plus1=0x00 and next fetch is 0x7E (wrap).
- Reset asserted mid-run with redirect=1 -> outputs all 0/valid=0, imem_addr=RESET_PC; with IFETCH_PERF_EN, counters read 0 and after 4 free-run cycles fetch_count=4, bubble_count=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter plus IF/ID pipeline register.
// Drives the PC as a word address to a combinational instruction memory and
// captures the returned word each cycle. Redirects flush IF/ID to an all-zero
// bubble and override stalls; stalls freeze both PC and IF/ID.
// Optional feature macro: IFETCH_PERF_EN adds fetch_count / bubble_count.
module instruction_fetch #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count,
`endif
    output logic              if_id_valid
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [31:0]       instr_reg, instr_next;
    logic [ADDR_W-1:0] pc_plus1_reg, pc_plus1_next;
    logic              valid_reg, valid_next;

    // Sequential successor wraps naturally at 2^ADDR_W.
    assign pc_inc    = pc_reg + ADDR_W'(1);
    assign imem_addr = pc_reg;

    // Next-state selection: redirect beats stall, stall beats normal fetch.
    always_comb begin
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        pc_plus1_next = pc_plus1_reg;
        valid_next    = valid_reg;
        if (redirect) begin
            pc_next       = redirect_target;
            instr_next    = 32'd0;
            pc_plus1_next = '0;
            valid_next    = 1'b0;
        end else if (!stall) begin
            pc_next       = pc_inc;
            instr_next    = imem_data;
            pc_plus1_next = pc_inc;
            valid_next    = 1'b1;
        end
    end

    // PC and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= RESET_PC_W;
            instr_reg    <= 32'd0;
            pc_plus1_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pc_plus1_reg <= pc_plus1_next;
            valid_reg    <= valid_next;
        end
    end

    assign if_id_instr    = instr_reg;
    assign if_id_pc_plus1 = pc_plus1_reg;
    assign if_id_valid    = valid_reg;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_reg, fetch_count_next;
    logic [31:0] bubble_count_reg, bubble_count_next;

    // Count edges that load a real instruction and edges that load a flush bubble.
    always_comb begin
        fetch_count_next  = fetch_count_reg;
        bubble_count_next = bubble_count_reg;
        if (redirect) begin
            bubble_count_next = bubble_count_reg + 32'd1;
        end else if (!stall) begin
            fetch_count_next = fetch_count_reg + 32'd1;
        end
    end

    // Performance counter registers; wrap at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_reg  <= 32'd0;
            bubble_count_reg <= 32'd0;
        end else begin
            fetch_count_reg  <= fetch_count_next;
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign fetch_count  = fetch_count_reg;
    assign bubble_count = bubble_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: each stimulus cycle pushes the
// hand-computed post-edge outputs; a negedge monitor pops and compares.
module tb_instruction_fetch;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic [31:0]   if_id_instr;
    logic [AW-1:0] if_id_pc_plus1;
    logic          if_id_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0]   fetch_count;
    logic [31:0]   bubble_count;
`endif

    logic [31:0] mem [0:255];
    assign imem_data = mem[imem_addr];

    int checks = 0;
    int failures = 0;
    int unsigned exp_fetch = 0;
    int unsigned exp_bubble = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [7:0]  pp1;
        logic        valid;
        logic [7:0]  addr;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } exp_t;

    exp_t sb [$];

    instruction_fetch #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus1  (if_id_pc_plus1),
`ifdef IFETCH_PERF_EN
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count),
`endif
        .if_id_valid     (if_id_valid)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, clock it, and queue the expected outputs.
    task automatic cyc(input string nm, input logic rst, input logic st,
                       input logic rd, input logic [7:0] tgt,
                       input logic [31:0] e_instr, input logic [7:0] e_pp1,
                       input logic e_valid, input logic [7:0] e_addr);
        exp_t e;
        reset = rst; stall = st; redirect = rd; redirect_target = tgt;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_fetch = 0; exp_bubble = 0;
        end else if (rd) begin
            exp_bubble++;
        end else if (!st) begin
            exp_fetch++;
        end
        e.name = nm; e.instr = e_instr; e.pp1 = e_pp1; e.valid = e_valid;
        e.addr = e_addr; e.fcnt = exp_fetch; e.bcnt = exp_bubble;
        sb.push_back(e);
        $display("cycle %-12s rst=%0b stall=%0b redir=%0b tgt=%02h -> exp instr=%08h pp1=%02h v=%0b addr=%02h",
                 nm, rst, st, rd, tgt, e_instr, e_pp1, e_valid, e_addr);
    endtask

    // Monitor: outputs are presented every cycle, compare at the negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (if_id_instr !== e.instr) begin
                failures++;
                $display("FAIL %s instr got=%08h exp=%08h", e.name, if_id_instr, e.instr);
            end
            checks++;
            if (if_id_pc_plus1 !== e.pp1) begin
                failures++;
                $display("FAIL %s pc_plus1 got=%02h exp=%02h", e.name, if_id_pc_plus1, e.pp1);
            end
            checks++;
            if (if_id_valid !== e.valid) begin
                failures++;
                $display("FAIL %s valid got=%0b exp=%0b", e.name, if_id_valid, e.valid);
            end
            checks++;
            if (imem_addr !== e.addr) begin
                failures++;
                $display("FAIL %s imem_addr got=%02h exp=%02h", e.name, imem_addr, e.addr);
            end
`ifdef IFETCH_PERF_EN
            checks++;
            if (fetch_count !== e.fcnt) begin
                failures++;
                $display("FAIL %s fetch_count got=%0d exp=%0d", e.name, fetch_count, e.fcnt);
            end
            checks++;
            if (bubble_count !== e.bcnt) begin
                failures++;
                $display("FAIL %s bubble_count got=%0d exp=%0d", e.name, bubble_count, e.bcnt);
            end
`endif
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'h0000_007E;
        mem[2] = 32'h0000_0005;
        mem[5] = 32'h0000_03FF;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;

        // Reset two cycles, then sequential fetch
        cyc("reset0",  1, 0, 0, 8'h00, 32'h0,   8'h00, 0, 8'h00);
        cyc("reset1",  1, 0, 0, 8'h00, 32'h0,   8'h00, 0, 8'h00);
        cyc("seq0",    0, 0, 0, 8'h00, 32'h7E,  8'h01, 1, 8'h01);
        cyc("seq1",    0, 0, 0, 8'h00, 32'h0,   8'h02, 1, 8'h02);
        cyc("seq2",    0, 0, 0, 8'h00, 32'h5,   8'h03, 1, 8'h03);
        // Stall three cycles: everything frozen
        cyc("stall0",  0, 1, 0, 8'h00, 32'h5,   8'h03, 1, 8'h03);
        cyc("stall1",  0, 1, 0, 8'h00, 32'h5,   8'h03, 1, 8'h03);
        cyc("stall2",  0, 1, 0, 8'h00, 32'h5,   8'h03, 1, 8'h03);
        cyc("seq3",    0, 0, 0, 8'h00, 32'h0,   8'h04, 1, 8'h04);
        cyc("seq4",    0, 0, 0, 8'h00, 32'h0,   8'h05, 1, 8'h05);
        cyc("seq5",    0, 0, 0, 8'h00, 32'h3FF, 8'h06, 1, 8'h06);
        // Move PC to 1, then redirect to 5 while PC=1
        cyc("redir1",  0, 0, 1, 8'h01, 32'h0,   8'h00, 0, 8'h01);
        cyc("redir5",  0, 0, 1, 8'h05, 32'h0,   8'h00, 0, 8'h05);
        cyc("tgt5",    0, 0, 0, 8'h00, 32'h3FF, 8'h06, 1, 8'h06);
        // Redirect and stall together: redirect wins
        cyc("rdst0",   0, 1, 1, 8'h00, 32'h0,   8'h00, 0, 8'h00);
        cyc("tgt0",    0, 0, 0, 8'h00, 32'h7E,  8'h01, 1, 8'h01);
        // Redirect to current PC: one bubble then refetch
        cyc("redirpc", 0, 0, 1, 8'h01, 32'h0,   8'h00, 0, 8'h01);
        cyc("refetch", 0, 0, 0, 8'h00, 32'h0,   8'h02, 1, 8'h02);
        // Wrap at 0xFF
        cyc("redirff", 0, 0, 1, 8'hFF, 32'h0,   8'h00, 0, 8'hFF);
        cyc("fetchff", 0, 0, 0, 8'h00, 32'h0,   8'h00, 1, 8'h00);
        cyc("wrap0",   0, 0, 0, 8'h00, 32'h7E,  8'h01, 1, 8'h01);
        // Reset mid-run with redirect and stall asserted: reset wins
        cyc("rstmid",  1, 1, 1, 8'h05, 32'h0,   8'h00, 0, 8'h00);
        cyc("free0",   0, 0, 0, 8'h00, 32'h7E,  8'h01, 1, 8'h01);
        cyc("free1",   0, 0, 0, 8'h00, 32'h0,   8'h02, 1, 8'h02);
        cyc("free2",   0, 0, 0, 8'h00, 32'h5,   8'h03, 1, 8'h03);
        cyc("free3",   0, 0, 0, 8'h00, 32'h0,   8'h04, 1, 8'h04);

        // Drain the scoreboard, bounded
        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
